wide_add_seq: RTL and testbench

WIDE_ADD_SEQ -- requirements
Module: wide_add_seq

---
 rtl/wide_add_seq.sv | 203 ++++++++++++++++++++
 tb/tb_wide_add_seq.sv | 372 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wide_add_seq.sv
// Sequential wide adder/subtractor: one N-bit carry-select slice is reused
// over W/N chunks, least-significant chunk first, behind a valid/ready
// handshake on each side.

// K-bit block adder, ripple (BLOCK_TYPE=0) or lookahead (BLOCK_TYPE=1).
module csa_blk #(
    parameter int unsigned K          = 8,
    parameter int unsigned BLOCK_TYPE = 0
) (
    input  logic [K-1:0] a,
    input  logic [K-1:0] b,
    input  logic         ci,
    output logic [K-1:0] s,
    output logic         co
);
    // Carry chain built from generate/propagate terms.
    always_comb begin
        logic [K-1:0] g;
        logic [K-1:0] p;
        logic [K:0]   c;
        logic         acc;
        logic         pp;
        g    = a & b;
        p    = a ^ b;
        c    = '0;
        c[0] = ci;
        for (int unsigned i = 0; i < K; i++) begin
            if (BLOCK_TYPE == 0) begin
                c[i+1] = g[i] | (p[i] & c[i]);
            end else begin
                // Each carry is expanded directly from g/p and ci.
                acc = g[i];
                pp  = p[i];
                for (int unsigned j = 0; j < i; j++) begin
                    acc = acc | (pp & g[i-1-j]);
                    pp  = pp & p[i-1-j];
                end
                c[i+1] = acc | (pp & ci);
            end
        end
        s  = p ^ c[K-1:0];
        co = c[K];
    end
endmodule

// N-bit carry-select adder made of N/K block pairs.
module csa_n #(
    parameter int unsigned N          = 16,
    parameter int unsigned K          = 8,
    parameter int unsigned BLOCK_TYPE = 0
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         ci,
    output logic [N-1:0] s,
    output logic         co
);
    localparam int unsigned NB = N / K;

    logic [N-1:0]  sum0;
    logic [N-1:0]  sum1;
    logic [NB-1:0] cy0;
    logic [NB-1:0] cy1;

    for (genvar i = 0; i < NB; i++) begin : g_blk
        csa_blk #(.K(K), .BLOCK_TYPE(BLOCK_TYPE)) u_b0 (
            .a(a[i*K +: K]), .b(b[i*K +: K]), .ci(1'b0),
            .s(sum0[i*K +: K]), .co(cy0[i])
        );
        csa_blk #(.K(K), .BLOCK_TYPE(BLOCK_TYPE)) u_b1 (
            .a(a[i*K +: K]), .b(b[i*K +: K]), .ci(1'b1),
            .s(sum1[i*K +: K]), .co(cy1[i])
        );
    end

    // Select each block's precomputed result with the incoming carry.
    always_comb begin
        logic c;
        s = '0;
        c = ci;
        for (int unsigned i = 0; i < NB; i++) begin
            s[i*K +: K] = c ? sum1[i*K +: K] : sum0[i*K +: K];
            c           = c ? cy1[i] : cy0[i];
        end
        co = c;
    end
endmodule

module wide_add_seq #(
    parameter int unsigned W          = 64,
    parameter int unsigned N          = 16,
    parameter int unsigned K          = 8,
    parameter int unsigned BLOCK_TYPE = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         ci,
    input  logic         op,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] s,
    output logic         co
);
    localparam int unsigned M  = W / N;
    localparam int unsigned CW = (M > 1) ? $clog2(M) : 1;
    localparam logic [CW-1:0] LAST = CW'(M - 1);

    if (N == 0 || K == 0 || (W % N) != 0 || (N % K) != 0 || M < 1) begin : g_param_check
        $error("wide_add_seq: W must be a multiple of N and N a multiple of K");
    end

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state_q, state_d;
    logic [W-1:0]  a_q, a_d;
    logic [W-1:0]  b_q, b_d;
    logic          carry_q, carry_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  s_q, s_d;
    logic          co_q, co_d;

    logic [N-1:0]  chunk_s;
    logic          chunk_co;

    csa_n #(.N(N), .K(K), .BLOCK_TYPE(BLOCK_TYPE)) u_slice (
        .a  (a_q[cnt_q*N +: N]),
        .b  (b_q[cnt_q*N +: N]),
        .ci (carry_q),
        .s  (chunk_s),
        .co (chunk_co)
    );

    // Next-state and datapath updates for the accept/run/done sequence.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        s_d     = s_q;
        co_d    = co_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    // Subtract is a + ~b + 1, so op only shapes b and the carry.
                    a_d     = a;
                    b_d     = op ? ~b : b;
                    carry_d = op ? 1'b1 : ci;
                    cnt_d   = '0;
                    s_d     = '0;
                    co_d    = 1'b0;
                    state_d = RUN;
                end
            end
            RUN: begin
                s_d[cnt_q*N +: N] = chunk_s;
                carry_d           = chunk_co;
                if (cnt_q == LAST) begin
                    co_d    = chunk_co;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            s_q     <= '0;
            co_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            s_q     <= s_d;
            co_q    <= co_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign s         = s_q;
    assign co        = co_q;
endmodule

// File: tb/tb_wide_add_seq.sv
// Bench for wide_add_seq: two 64-bit instances (ripple and lookahead blocks)
// sharing stimulus, plus a single-chunk 16-bit instance.
module tb_wide_add_seq;
    localparam int unsigned M = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        in_valid, out_ready, ci, op;
    logic [63:0] a, b;
    logic        in_ready0, out_valid0, co0;
    logic        in_ready1, out_valid1, co1;
    logic [63:0] s0, s1;

    logic        in_valid16, out_ready16, ci16, op16;
    logic [15:0] a16, b16, s16;
    logic        in_ready16, out_valid16, co16;

    int errors = 0;
    int checks = 0;

    wide_add_seq #(.W(64), .N(16), .K(8), .BLOCK_TYPE(0)) u_rca (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
        .a(a), .b(b), .ci(ci), .op(op), .out_valid(out_valid0),
        .out_ready(out_ready), .s(s0), .co(co0)
    );

    wide_add_seq #(.W(64), .N(16), .K(4), .BLOCK_TYPE(1)) u_cla (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
        .a(a), .b(b), .ci(ci), .op(op), .out_valid(out_valid1),
        .out_ready(out_ready), .s(s1), .co(co1)
    );

    wide_add_seq #(.W(16), .N(16), .K(8), .BLOCK_TYPE(0)) u_m1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid16), .in_ready(in_ready16),
        .a(a16), .b(b16), .ci(ci16), .op(op16), .out_valid(out_valid16),
        .out_ready(out_ready16), .s(s16), .co(co16)
    );

    // Reference: plain arithmetic; subtract gives difference and a>=b as no-borrow.
    function automatic logic [64:0] ref64(input logic [63:0] x, input logic [63:0] y,
                                          input logic c, input logic o);
        if (o) return {x >= y, x - y};
        return {1'b0, x} + {1'b0, y} + 65'(c);
    endfunction

    function automatic logic [16:0] ref16(input logic [15:0] x, input logic [15:0] y,
                                          input logic c, input logic o);
        if (o) return {x >= y, x - y};
        return {1'b0, x} + {1'b0, y} + 17'(c);
    endfunction

    // One transaction on the 64-bit pair; lat is the cycle out_valid is first seen (accept = 0).
    task automatic run_txn(input logic [63:0] xa, input logic [63:0] xb, input logic xc,
                           input logic xo, input bit noise,
                           output logic [63:0] r0, output logic [63:0] r1,
                           output logic c0, output logic c1, output int lat);
        int w;
        w = 0;
        while (!(in_ready0 && in_ready1) && w < 50) begin
            @(negedge clk);
            w++;
        end
        a = xa; b = xb; ci = xc; op = xo; in_valid = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        lat = 1;
        in_valid = noise;
        while (!out_valid0 && lat < 50) begin
            if (noise) begin
                a = {$urandom, $urandom}; b = {$urandom, $urandom};
                ci = 1'($urandom); op = 1'($urandom);
            end
            @(negedge clk);
            lat++;
        end
        if (w >= 50) lat = -1;
        r0 = s0; r1 = s1; c0 = co0; c1 = co1;
        in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({in_ready0, out_valid0, co0} !== 3'b100 || s0 !== 64'h0) begin
            errors++;
            $display("FAIL reset_rca: rdy/vld/co=%b s=%h, required 100 s=0",
                     {in_ready0, out_valid0, co0}, s0);
        end
        checks++;
        if ({in_ready1, out_valid1, co1} !== 3'b100 || s1 !== 64'h0) begin
            errors++;
            $display("FAIL reset_cla: rdy/vld/co=%b s=%h, required 100 s=0",
                     {in_ready1, out_valid1, co1}, s1);
        end
        checks++;
        if ({in_ready16, out_valid16, co16} !== 3'b100 || s16 !== 16'h0) begin
            errors++;
            $display("FAIL reset_m1: rdy/vld/co=%b s=%h, required 100 s=0",
                     {in_ready16, out_valid16, co16}, s16);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_add_carry();
        logic [63:0] r0, r1;
        logic        c0, c1;
        int          lat;
        run_txn(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 1'b0, r0, r1, c0, c1, lat);
        checks++;
        if (lat !== M + 1) begin
            errors++;
            $display("FAIL add_carry_latency: got %0d, required %0d", lat, M + 1);
        end
        checks++;
        if (r0 !== 64'h0 || c0 !== 1'b1) begin
            errors++;
            $display("FAIL add_carry_rca: got s=%h co=%b, required s=0 co=1", r0, c0);
        end
        checks++;
        if (r1 !== 64'h0 || c1 !== 1'b1) begin
            errors++;
            $display("FAIL add_carry_cla: got s=%h co=%b, required s=0 co=1", r1, c1);
        end
    endtask

    task automatic test_subtract();
        logic [63:0] r0, r1;
        logic        c0, c1;
        int          lat;
        run_txn(64'd5, 64'd7, 1'b1, 1'b1, 1'b1, r0, r1, c0, c1, lat);
        checks++;
        if (r0 !== 64'hFFFF_FFFF_FFFF_FFFE || c0 !== 1'b0 || r1 !== r0 || c1 !== c0) begin
            errors++;
            $display("FAIL sub_5_7: got s=%h/%h co=%b/%b, required s=fffffffffffffffe co=0",
                     r0, r1, c0, c1);
        end
        run_txn(64'd7, 64'd5, 1'b0, 1'b1, 1'b1, r0, r1, c0, c1, lat);
        checks++;
        if (r0 !== 64'd2 || c0 !== 1'b1 || r1 !== 64'd2 || c1 !== 1'b1) begin
            errors++;
            $display("FAIL sub_7_5: got s=%h/%h co=%b/%b, required s=2 co=1", r0, r1, c0, c1);
        end
    endtask

    task automatic test_random_single();
        logic [63:0] r0, r1, xa, xb;
        logic        c0, c1, xc, xo;
        logic [64:0] e;
        int          lat;
        for (int i = 0; i < 20; i++) begin
            xa = {$urandom, $urandom}; xb = {$urandom, $urandom};
            if (i % 5 == 0) xb = xa;
            xc = 1'($urandom); xo = 1'($urandom);
            e = ref64(xa, xb, xc, xo);
            run_txn(xa, xb, xc, xo, 1'b1, r0, r1, c0, c1, lat);
            checks++;
            if ({c0, r0} !== e || {c1, r1} !== e || lat !== M + 1) begin
                errors++;
                $display("FAIL random_single[%0d]: got co,s=%h/%h lat=%0d, required %h lat=%0d",
                         i, {c0, r0}, {c1, r1}, lat, e, M + 1);
            end
        end
    endtask

    task automatic test_hold();
        logic [64:0] ex, ey;
        logic [63:0] ya, yb;
        int          lat;
        ex = ref64(64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 1'b1, 1'b0);
        a = 64'h0123_4567_89AB_CDEF; b = 64'hFEDC_BA98_7654_3210; ci = 1'b1; op = 1'b0;
        in_valid = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid0 && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        ya = {$urandom, $urandom}; yb = {$urandom, $urandom};
        a = ya; b = yb; ci = 1'b0; op = 1'b1; in_valid = 1'b1;
        ey = ref64(ya, yb, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (out_valid0 !== 1'b1 || in_ready0 !== 1'b0 || {co0, s0} !== ex || {co1, s1} !== ex) begin
                errors++;
                $display("FAIL hold[%0d]: vld=%b rdy=%b co,s=%h/%h, required vld=1 rdy=0 %h",
                         i, out_valid0, in_ready0, {co0, s0}, {co1, s1}, ex);
            end
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checks++;
        if (in_ready0 !== 1'b1 || out_valid0 !== 1'b0) begin
            errors++;
            $display("FAIL hold_release_idle: rdy=%b vld=%b, required rdy=1 vld=0", in_ready0, out_valid0);
        end
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (in_ready0 !== 1'b0) begin
            errors++;
            $display("FAIL hold_next_accept: rdy=%b, required 0", in_ready0);
        end
        lat = 1;
        while (!out_valid0 && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        checks++;
        if ({co0, s0} !== ey || {co1, s1} !== ey || lat !== M + 1) begin
            errors++;
            $display("FAIL hold_new_result: co,s=%h/%h lat=%0d, required %h lat=%0d",
                     {co0, s0}, {co1, s1}, lat, ey, M + 1);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid_run();
        logic [63:0] r0, r1;
        logic        c0, c1;
        int          lat;
        a = {$urandom, $urandom}; b = {$urandom, $urandom}; ci = 1'b1; op = 1'b0;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid0 !== 1'b0 || in_ready0 !== 1'b1 || s0 !== 64'h0 ||
            out_valid1 !== 1'b0 || in_ready1 !== 1'b1 || s1 !== 64'h0) begin
            errors++;
            $display("FAIL reset_mid_run: vld=%b rdy=%b s=%h, required vld=0 rdy=1 s=0",
                     out_valid0, in_ready0, s0);
        end
        rst_n = 1'b1;
        run_txn(64'h1234, 64'h1, 1'b0, 1'b0, 1'b0, r0, r1, c0, c1, lat);
        checks++;
        if (r0 !== 64'h1235 || c0 !== 1'b0 || r1 !== 64'h1235 || c1 !== 1'b0 || lat !== M + 1) begin
            errors++;
            $display("FAIL after_reset_add: s=%h/%h co=%b/%b lat=%0d, required s=1235 co=0 lat=%0d",
                     r0, r1, c0, c1, lat, M + 1);
        end
    endtask

    task automatic test_m1();
        int lat;
        a16 = 16'h8000; b16 = 16'h8000; ci16 = 1'b1; op16 = 1'b0;
        in_valid16 = 1'b1; out_ready16 = 1'b0;
        @(negedge clk);
        in_valid16 = 1'b0;
        lat = 1;
        while (!out_valid16 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        checks++;
        if (lat !== 2) begin
            errors++;
            $display("FAIL m1_latency: got %0d, required 2", lat);
        end
        checks++;
        if (s16 !== 16'h0001 || co16 !== 1'b1) begin
            errors++;
            $display("FAIL m1_add: got s=%h co=%b, required s=0001 co=1", s16, co16);
        end
        out_ready16 = 1'b1;
        @(negedge clk);
        out_ready16 = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [64:0] q64[$];
        logic [16:0] q16[$];
        logic [64:0] e64;
        logic [16:0] e16;
        int n64, n16, cyc, last64, last16;
        n64 = 0; n16 = 0; cyc = 0; last64 = -1; last16 = -1;
        in_valid = 1'b1; out_ready = 1'b1; in_valid16 = 1'b1; out_ready16 = 1'b1;
        while ((n64 < 1000 || n16 < 1000) && cyc < 20000) begin
            if (out_valid0) begin
                checks++;
                if (q64.size() == 0) begin
                    errors++;
                    $display("FAIL b2b64_unexpected: result s=%h with nothing accepted", s0);
                end else begin
                    e64 = q64.pop_front();
                    if ({co0, s0} !== e64 || {co1, s1} !== e64 || out_valid1 !== 1'b1) begin
                        errors++;
                        $display("FAIL b2b64[%0d]: co,s=%h/%h vld1=%b, required %h",
                                 n64, {co0, s0}, {co1, s1}, out_valid1, e64);
                    end
                end
                if (last64 >= 0) begin
                    checks++;
                    if (cyc - last64 !== M + 2) begin
                        errors++;
                        $display("FAIL b2b64_period: got %0d, required %0d", cyc - last64, M + 2);
                    end
                end
                last64 = cyc;
                n64++;
            end
            if (out_valid16) begin
                checks++;
                if (q16.size() == 0) begin
                    errors++;
                    $display("FAIL b2b16_unexpected: result s=%h with nothing accepted", s16);
                end else begin
                    e16 = q16.pop_front();
                    if ({co16, s16} !== e16) begin
                        errors++;
                        $display("FAIL b2b16[%0d]: co,s=%h, required %h", n16, {co16, s16}, e16);
                    end
                end
                if (last16 >= 0) begin
                    checks++;
                    if (cyc - last16 !== 3) begin
                        errors++;
                        $display("FAIL b2b16_period: got %0d, required 3", cyc - last16);
                    end
                end
                last16 = cyc;
                n16++;
            end
            a = {$urandom, $urandom}; b = {$urandom, $urandom};
            ci = 1'($urandom); op = 1'($urandom);
            a16 = 16'($urandom); b16 = 16'($urandom);
            ci16 = 1'($urandom); op16 = 1'($urandom);
            if (in_ready0) q64.push_back(ref64(a, b, ci, op));
            if (in_ready16) q16.push_back(ref16(a16, b16, ci16, op16));
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (n64 < 1000 || n16 < 1000) begin
            errors++;
            $display("FAIL b2b_timeout: got %0d/%0d results, required 1000 each", n64, n16);
        end
        in_valid = 1'b0; in_valid16 = 1'b0; out_ready = 1'b0; out_ready16 = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0; out_ready = 1'b0; ci = 1'b0; op = 1'b0; a = '0; b = '0;
        in_valid16 = 1'b0; out_ready16 = 1'b0; ci16 = 1'b0; op16 = 1'b0; a16 = '0; b16 = '0;
        @(negedge clk);
        test_reset();
        test_add_carry();
        test_subtract();
        test_random_single();
        test_hold();
        test_reset_mid_run();
        test_m1();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
